// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// the scan FSM states, the blanked-segment value and the hex glyph table.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } seg_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; 7 lights only a,b,c, letters render as A b C d E F.
  localparam logic [6:0] SEG_HEX_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = SEG_HEX_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Single-clock multiplexed seven-segment scanner with frame-aligned load commit.
// Optional decimal-point support is compiled in with the SEG_DP_EN macro.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int PRESCALE_BITS = 17,
  parameter int NUM_DIGITS    = 8,
  parameter int BLANK_CYCLES  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [6:0]              cathode_n,
  output logic                    frame_done,
`ifdef SEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic                    dp_n,
`endif
  output logic                    dbg_state
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESCALE_BITS-1:0] BLANK_LAST = PRESCALE_BITS'(BLANK_CYCLES - 1);

  // Load handshake: a load transfers on any clock where load_valid && load_ready.
  // load_ready stays low from acceptance until the frame boundary that commits it.

  logic [PRESCALE_BITS-1:0] r_presc;
  seg_state_t               r_state;
  seg_state_t               w_state_next;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_idx_next;
  logic                     w_slot_end;
  logic                     w_frame_wrap;
  logic                     w_accept;
  logic                     w_commit;

  logic                     r_pending;
  logic [4*NUM_DIGITS-1:0]  r_pend_buf;
  logic [4*NUM_DIGITS-1:0]  r_shadow;
  logic                     r_wrapped;

  logic [3:0]               w_nibble;
  logic [6:0]               w_seg_n;
  logic                     w_digit_on;
  logic [NUM_DIGITS-1:0]    w_anode_next;
  logic [6:0]               w_cathode_next;

  logic [NUM_DIGITS-1:0]    r_anode_n;
  logic [6:0]               r_cathode_n;
  logic                     r_frame_done;

  assign w_slot_end   = (r_presc == '1);
  assign w_frame_wrap = w_slot_end && (r_idx == LAST_IDX);
  assign w_accept     = load_valid && !r_pending;
  assign w_commit     = w_frame_wrap && r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BLANK;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // The state tracks the prescaler value: SHOW once it reaches BLANK_CYCLES.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (w_slot_end) begin
      w_state_next = BLANK;
      w_idx_next   = w_frame_wrap ? '0 : r_idx + 1'b1;
    end else if ((r_state == BLANK) && (r_presc == BLANK_LAST)) begin
      w_state_next = SHOW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= 1'b0;
      r_pend_buf <= '0;
      r_shadow   <= '0;
    end else begin
      if (w_accept) begin
        r_pend_buf <= load_data;
        r_pending  <= 1'b1;
      end else if (w_commit) begin
        r_pending  <= 1'b0;
      end
      if (w_commit) begin
        r_shadow <= r_pend_buf;
      end
    end
  end

  assign w_nibble   = r_shadow[4*r_idx +: 4];
  assign w_digit_on = (r_state == SHOW) && digit_en[r_idx];

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_n)
  );

  always_comb begin
    w_anode_next   = '1;
    w_cathode_next = SEG_OFF;
    if (w_digit_on) begin
      w_anode_next[r_idx] = 1'b0;
      w_cathode_next      = w_seg_n;
    end
  end

  // frame_done lags the wrap edge by one clock like the other display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_anode_n    <= '1;
      r_cathode_n  <= SEG_OFF;
      r_wrapped    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_anode_n    <= w_anode_next;
      r_cathode_n  <= w_cathode_next;
      r_wrapped    <= w_frame_wrap;
      r_frame_done <= r_wrapped;
    end
  end

`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0] r_dp_pend;
  logic [NUM_DIGITS-1:0] r_dp_shadow;
  logic                  r_dp_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dp_pend   <= '0;
      r_dp_shadow <= '0;
      r_dp_n      <= 1'b1;
    end else begin
      if (w_accept) begin
        r_dp_pend <= load_dp;
      end
      if (w_commit) begin
        r_dp_shadow <= r_dp_pend;
      end
      r_dp_n <= w_digit_on ? !r_dp_shadow[r_idx] : 1'b1;
    end
  end

  assign dp_n = r_dp_n;
`endif

  assign load_ready = !r_pending;
  assign anode_n    = r_anode_n;
  assign cathode_n  = r_cathode_n;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized scoreboard bench for seg_scan_controller using a cycle-count
// reference model of the scan schedule and frame-aligned load commit.
module tb_seg_scan_controller;

  localparam int PB    = 4;
  localparam int ND    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = 1 << PB;
  localparam int FRAME = SLOT * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  anode_n;
  logic [6:0]  cathode_n;
  logic        frame_done;
  logic        dbg_state;
`ifdef SEG_DP_EN
  logic [3:0]  load_dp = '0;
  logic        dp_n;
`endif

  seg_scan_controller #(
    .PRESCALE_BITS (PB),
    .NUM_DIGITS    (ND),
    .BLANK_CYCLES  (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .digit_en   (digit_en),
    .anode_n    (anode_n),
    .cathode_n  (cathode_n),
    .frame_done (frame_done),
`ifdef SEG_DP_EN
    .load_dp    (load_dp),
    .dp_n       (dp_n),
`endif
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];
  logic [13:0] mon_e;

  // reference model: k is the number of the upcoming clock edge since reset release
  int          k = 0;
  logic        m_pending = 1'b0;
  logic [15:0] m_buf = '0;
  logic [15:0] m_shadow = '0;
  logic [6:0]  seg_tab [16];

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [10:0] display_at(input int kk, input logic [3:0] en,
                                             input logic [15:0] sh);
    logic [3:0] an;
    logic [6:0] ca;
    int p;
    int d;
    an = 4'hF;
    ca = 7'h7F;
    if (kk >= 1) begin
      p = (kk - 1) % SLOT;
      d = ((kk - 1) / SLOT) % ND;
      if (p >= BC && en[d]) begin
        an = ~(4'b0001 << d);
        ca = seg_tab[sh[4*d +: 4]];
      end
    end
    return {an, ca};
  endfunction

  task automatic push_edge();
    logic [10:0] disp;
    logic        acc;
    logic        fd;
    logic        st;
    disp = display_at(k, digit_en, m_shadow);
    acc  = load_valid && !m_pending;
    if ((k % FRAME == 0) && (k > 0) && m_pending) begin
      m_shadow  = m_buf;
      m_pending = 1'b0;
    end
    if (acc) begin
      m_buf     = load_data;
      m_pending = 1'b1;
    end
    fd = (k % FRAME == 1) && (k > 1);
    st = (k % SLOT) >= BC;
    exp_q.push_back({fd, !m_pending, st, disp});
    k++;
  endtask

  task automatic step(input logic lv, input logic [15:0] ld, input logic [3:0] en);
    @(negedge clk);
    load_valid = lv;
    load_data  = ld;
    digit_en   = en;
    push_edge();
  endtask

  task automatic run_idle_until(input int m);
    while (k % FRAME != m) step(1'b0, 16'h0000, 4'hF);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 rst = 1'b0;
    load_valid = 1'b0;
    #1;
    check("reset_outputs", 14'({anode_n, cathode_n, frame_done, load_ready}),
          14'({4'hF, 7'h7F, 1'b0, 1'b1}));
    repeat (hold) @(negedge clk);
    exp_q.delete();
    m_pending = 1'b0;
    m_buf     = '0;
    m_shadow  = '0;
    k         = 1;
    digit_en  = 4'hF;
    rst       = 1'b1;
    push_edge();
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("display", 14'({anode_n, cathode_n}), 14'(mon_e[10:0]));
      check("flags", 14'({frame_done, load_ready, dbg_state}), 14'(mon_e[13:11]));
    end
  end

  initial begin
    logic [6:0] seg_on [16];
    logic [3:0] en;
    seg_on = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 16; i++) seg_tab[i] = ~seg_on[i];

    #2 rst = 1'b0;
    do_reset(3);

    // load mid-frame, then a held-off second offer while pending
    run_idle_until(20);
    step(1'b1, 16'h3210, 4'hF);
    for (int i = 0; i < 5; i++) step(1'b1, 16'hBEEF, 4'hF);
    run_idle_until(8);
    run_idle_until(0);

    // offer exactly on the wrap edge: committed one frame later
    step(1'b1, 16'hA5C7, 4'hF);
    run_idle_until(0);
    run_idle_until(0);

    // digit 2 masked off for two frames
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'h0000, 4'b1011);

    en = 4'hF;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) en = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 7) == 0), 16'($urandom), en);
    end

    // reset during digit 3 SHOW with a load still pending
    run_idle_until(1);
    run_idle_until(40);
    step(1'b1, 16'($urandom), 4'hF);
    run_idle_until(56);
    do_reset(2);

    run_idle_until(0);
    run_idle_until(0);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drain", 14'(exp_q.size()), 14'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan controller for the board's multi-digit seven-segment display. It replaces the ripple T-flip-flop clock chain with a single-clock prescaler that issues clock enables, so the whole block runs on the system clock. Each prescaler period it rotates the active anode through the digits and blanks between digits to suppress ghosting. New display contents enter through a valid/ready handshake and are committed only at frame boundaries.

## Interface
- PRESCALE_BITS, 17: one digit slot lasts 2^PRESCALE_BITS clocks (1.31 ms at 100 MHz).
- NUM_DIGITS, 8: number of multiplexed digits; must be ≥ 2.
- BLANK_CYCLES, 1024: clocks at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < 2^PRESCALE_BITS.
- clk  in  1  system clock; one clock domain only.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  a new display value is offered.
- load_data  in  4*NUM_DIGITS  hex nibble per digit; digit 0 is in [3:0].
- load_ready  out  1  block can accept a load.
- digit_en  in  NUM_DIGITS  live per-digit enable mask; 0 keeps that digit dark.
- anode_n  out  NUM_DIGITS  active-low digit select.
- cathode_n  out  7  active-low segments, {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse each time the digit index wraps to 0.

## Operation
- The prescaler is a PRESCALE_BITS-bit free-running up-counter. It wraps from all-ones to 0. The wrap is the slot boundary.
- FSM states: BLANK and SHOW.
  - At a slot boundary the state goes to BLANK and digit index idx advances, wrapping from NUM_DIGITS-1 to 0.
  - When prescaler == BLANK_CYCLES the state goes from BLANK to SHOW.
- Outputs by state:
  - BLANK: anode_n is all ones, cathode_n = 7'h7F.
  - SHOW: anode_n[idx] = 0 only if digit_en[idx] = 1; all other anode bits are 1. cathode_n = hex decode of shadow[idx].
  - A digit with digit_en[idx] = 0 drives cathode_n = 7'h7F.
- Hex decode:
  - 0–9 use standard patterns, with 7 as a,b,c.
  - A–F: A, b, C, d, E, F.
- Load path:
  - load_ready = !pending.
  - On load_valid && load_ready, capture load_data into the pending buffer and set pending.
  - At a frame boundary (idx wrapping to 0) with pending set: shadow ← pending buffer, pending clears, load_ready rises on the next cycle.
  - The display never changes contents mid-frame.
- Simultaneous events:
  - A load accepted on the frame-boundary edge goes into pending. It is committed at the following frame boundary, not the current one.
  - The transfer uses pending as registered before the edge.
- Reset (asynchronous, any time including mid-frame) sets:
  - prescaler = 0, idx = 0, state = BLANK.
  - shadow = all zeros, pending = 0, load_ready = 1.
  - anode_n = all ones, cathode_n = 7'h7F, frame_done = 0.
  - Any un-committed load is discarded.

## Timing
- anode_n, cathode_n and frame_done are registered. They change one clock after the state/idx edge that causes them.
- The first slot after reset release is digit 0, BLANK for BLANK_CYCLES clocks.
- The frame period is NUM_DIGITS × 2^PRESCALE_BITS clocks. frame_done asserts once per frame.
- Load-to-display latency is at most one frame plus two slots' worth of clocks.
- A change on digit_en is visible on anode_n one clock later.

## Configuration
- SEG_DP_EN defined:
  - Adds input load_dp[NUM_DIGITS], captured and committed together with load_data.
  - Adds output dp_n. In SHOW, dp_n = !dp_shadow[idx] gated by digit_en[idx]; otherwise dp_n = 1. Reset value is 1.
- SEG_DP_EN undefined: neither port nor any of their storage exists.

## Structure
- Package seg_pkg holds:
  - the state enum (BLANK, SHOW);
  - SEG_OFF = 7'h7F;
  - the 16-entry hex-to-segment constant table.
- Sub-module hex_to_7seg: a purely combinational nibble to active-low segment decoder.
- The controller holds the prescaler, FSM, idx, and the pending and shadow registers.

## Test plan
All scenarios use PRESCALE_BITS=4, BLANK_CYCLES=2, NUM_DIGITS=4.
- Reset release → anode_n=4'hF and cathode_n=7'h7F for the first 3 clocks; anode_n=4'b1110 from clock 3 to 16.
- Load 16'h3210 mid-frame → digits still show 0 (7'h40) until the wrap; next frame digit 2 shows 7'h24; load_ready is low from accept until one clock after the wrap.
- Second load_valid while pending → held off with load_ready=0. A load in the exact wrap cycle → committed one frame later.
- digit_en=4'b1011 → anode_n stays 4'hF and cathode_n stays 7'h7F during digit 2's slot; the other digits are unaffected.
- frame_done → exactly one pulse every 64 clocks, aligned with idx returning to 0.
- rst low mid-SHOW of digit 3 with a pending load → all outputs at reset values immediately; after release, shadow shows 0 and load_ready=1.
